// File: rtl/psx_pkg.sv
// Shared definitions for the fake PSX digital-pad controller: FSM states,
// the fixed response/command bytes and the response byte selector.
package psx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT     = 3'd1,
    ST_ACK_WAIT  = 3'd2,
    ST_ACK_PULSE = 3'd3,
    ST_IGNORE    = 3'd4
  } state_e;

  // Bytes the pad returns at indices 0..2 (idle filler, digital-pad ID, ready).
  localparam logic [7:0] RESP_IDLE  = 8'hFF;
  localparam logic [7:0] RESP_ID    = 8'h41;
  localparam logic [7:0] RESP_READY = 8'h5A;

  // Bytes the host must send at indices 0 and 1 for the poll to be accepted.
  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_POLL  = 8'h42;

  localparam int         NUM_BYTES = 5;
  localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);

  // Byte the pad drives for a given index; the last two carry the buttons.
  function automatic logic [7:0] resp_byte(input logic [2:0] idx,
                                           input logic [15:0] hold);
    case (idx)
      3'd0:    return RESP_IDLE;
      3'd1:    return RESP_ID;
      3'd2:    return RESP_READY;
      3'd3:    return hold[7:0];
      default: return hold[15:8];
    endcase
  endfunction

endpackage

// File: rtl/psx_sync.sv
// Two-flop synchronizer for one host line plus edge detection on the
// synchronized value. All flops idle high, matching the idle bus level.
module psx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Sample the asynchronous line, settle it, and keep one cycle of history.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // and the chain really is three stages deep.
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/fake_psx_controller.sv
// Emulates a PlayStation digital pad on the controller port: answers a
// 01 42 00 00 00 poll with FF 41 5A <buttons lo> <buttons hi>, pulsing ack
// after every byte except the last. ACK_DELAY and ACK_WIDTH must be >= 1.
module fake_psx_controller
  import psx_pkg::*;
#(
  parameter int ACK_DELAY = 6,
  parameter int ACK_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic        att,
  input  logic [15:0] buttons,
  output logic        data,
  output logic        ack,
  output logic        busy
);

  localparam int TMR_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(ACK_DELAY - 1);
  localparam logic [TMR_W-1:0] WIDTH_LAST = TMR_W'(ACK_WIDTH - 1);

  // Synchronized host lines.
  logic psx_clk_level, psx_clk_rise, psx_clk_fall;
  logic cmd_level, cmd_rise, cmd_fall;
  logic att_level, att_rise, att_fall;
  logic sync_unused;

  psx_sync u_sync_psx_clk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (psx_clk),
    .level (psx_clk_level),
    .rise  (psx_clk_rise),
    .fall  (psx_clk_fall)
  );

  psx_sync u_sync_cmd (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cmd),
    .level (cmd_level),
    .rise  (cmd_rise),
    .fall  (cmd_fall)
  );

  psx_sync u_sync_att (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (att),
    .level (att_level),
    .rise  (att_rise),
    .fall  (att_fall)
  );

  assign sync_unused = &{psx_clk_level, cmd_rise, cmd_fall, att_level};

  // Registered state.
  state_e           state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [7:0]       rx_q, rx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             data_q, data_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [1:0]       settle_q;

  logic       settled;
  logic       start;
  logic [7:0] rx_shift;
  logic [7:0] cur_resp;
  logic       cmd_bad;

  // The synchronizers reset high, so a line held low through reset would
  // look like a falling edge; att falls are only trusted once the pipeline
  // holds real samples, forcing a fresh att fall after reset.
  assign settled  = (settle_q == 2'd3);
  assign start    = att_fall & settled;
  assign rx_shift = {cmd_level, rx_q[7:1]};
  assign cur_resp = resp_byte(byte_q, hold_q);
  assign cmd_bad  = ((byte_q == 3'd0) && (rx_shift != CMD_START)) ||
                    ((byte_q == 3'd1) && (rx_shift != CMD_POLL));

  // Count the cycles needed to flush the reset value out of the synchronizers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= 2'd0;
    end else if (!settled) begin
      settle_q <= settle_q + 2'd1;
    end
  end

  // State and datapath registers, outputs included so they never glitch.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      rx_q    <= '0;
      tmr_q   <= '0;
      data_q  <= 1'b1;
      ack_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      rx_q    <= rx_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; att has priority over any psx_clk edge in the same cycle.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    hold_d  = hold_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    rx_d    = rx_q;
    tmr_d   = tmr_q;
    data_d  = data_q;

    if ((state_q != ST_IDLE) && att_rise) begin
      state_d = ST_IDLE;
      data_d  = 1'b1;
      tmr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          data_d = 1'b1;
          if (start) begin
            hold_d  = buttons;
            bit_d   = '0;
            byte_d  = '0;
            rx_d    = '0;
            state_d = ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (psx_clk_fall) begin
            data_d = cur_resp[bit_q];
          end else if (psx_clk_rise) begin
            rx_d  = rx_shift;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (cmd_bad || (byte_q == LAST_BYTE)) begin
                state_d = ST_IGNORE;
                data_d  = 1'b1;
              end else begin
                state_d = ST_ACK_WAIT;
                tmr_d   = '0;
              end
            end
          end
        end

        ST_ACK_WAIT: begin
          tmr_d = tmr_q + TMR_W'(1);
          if (tmr_q == DELAY_LAST) begin
            state_d = ST_ACK_PULSE;
            tmr_d   = '0;
          end
        end

        ST_ACK_PULSE: begin
          tmr_d = tmr_q + TMR_W'(1);
          if (tmr_q == WIDTH_LAST) begin
            state_d = ST_SHIFT;
            tmr_d   = '0;
            byte_d  = byte_q + 3'd1;
          end
        end

        ST_IGNORE: begin
          data_d = 1'b1;
        end

        default: begin
          state_d = ST_IDLE;
          data_d  = 1'b1;
        end
      endcase
    end

    ack_d  = (state_d != ST_ACK_PULSE);
    busy_d = (state_d != ST_IDLE);
  end

  assign data = data_q;
  assign ack  = ack_q;
  assign busy = busy_q;

endmodule
